imul: RTL and testbench

IMUL -- requirements
Module: imul

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/imul_if.sv | 22 ++
 rtl/imul_negate.sv | 10 +
 rtl/imul.sv | 109 ++++++++++
 tb/tb_imul.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the integer multiply unit: op encoding, FSM states, width default.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    NEG,
    DONE
  } imul_state_e;

endpackage

// File: rtl/imul_if.sv
// Pipeline <-> multiplier handshake: start/kill/operands in, stall/writeback out.
interface imul_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic [3:0]      mul_inst;
  logic            kill;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall_i;
  logic            mul_wb;
  logic [XLEN-1:0] rd_data;

  modport master (
    output mul_inst, kill, rs1_data, rs2_data,
    input  stall_i, mul_wb, rd_data
  );

  modport slave (
    input  mul_inst, kill, rs1_data, rs2_data,
    output stall_i, mul_wb, rd_data
  );
endinterface

// File: rtl/imul_negate.sv
// Width-generic two's-complement negation, passes the input through when en=0.
module imul_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = en ? (~din + W'(1)) : din;
endmodule

// File: rtl/imul.sv
// Sequential radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes up front, multiplied unsigned over XLEN
// cycles, and the product is negated in a separate cycle only when needed.
module imul
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input logic   clk,
  input logic   reset,
  imul_if.slave bus
);

  imul_state_e       state, state_nxt;
  logic [5:0]        cnt;
  mul_op_e           op_q, op_dec;
  logic              neg_q;
  logic [XLEN-1:0]   mcand_q;
  // High half accumulates; low half starts as the multiplier and is shifted out LSB first.
  logic [2*XLEN-1:0] prod_q, prod_step, prod_neg, prod_nxt;
  logic [XLEN:0]     add_sum;
  logic [XLEN-1:0]   rd_q, mag1, mag2;
  logic              accept, s1, s2, neg1_en, neg2_en;

  // Decode the one-hot request and decide which operands are signed.
  always_comb begin
    op_dec = MUL;
    if (bus.mul_inst[1])      op_dec = MULH;
    else if (bus.mul_inst[2]) op_dec = MULHSU;
    else if (bus.mul_inst[3]) op_dec = MULHU;
  end

  assign s1      = (op_dec != MULHU);
  assign s2      = (op_dec == MUL) || (op_dec == MULH);
  assign neg1_en = s1 & bus.rs1_data[XLEN-1];
  assign neg2_en = s2 & bus.rs2_data[XLEN-1];
  assign accept  = (state == IDLE) && $onehot(bus.mul_inst) && !bus.kill;

  imul_negate #(.W(XLEN))   u_neg_rs1  (.en(neg1_en), .din(bus.rs1_data), .dout(mag1));
  imul_negate #(.W(XLEN))   u_neg_rs2  (.en(neg2_en), .din(bus.rs2_data), .dout(mag2));
  imul_negate #(.W(2*XLEN)) u_neg_prod (.en(neg_q),   .din(prod_q),       .dout(prod_neg));

  // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
  always_comb begin
    add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    prod_step = {add_sum, prod_q[XLEN-1:1]};
    prod_nxt  = prod_q;
    if (state == RUN)      prod_nxt = prod_step;
    else if (state == NEG) prod_nxt = prod_neg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; kill returns to IDLE from any busy state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.kill)                     state_nxt = IDLE;
        else if (cnt == 6'(XLEN-1))       state_nxt = neg_q ? NEG : DONE;
      end
      NEG:  state_nxt = bus.kill ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: stall covers the accept cycle plus RUN/NEG, writeback is the DONE cycle.
  always_comb begin
    bus.stall_i = accept || (state == RUN) || (state == NEG);
    bus.mul_wb  = (state == DONE);
  end

  // Datapath: latch operands on accept, iterate in RUN, negate in NEG,
  // and capture the result word on the way into DONE so it holds afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      op_q    <= MUL;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_dec;
        neg_q   <= neg1_en ^ neg2_en;
        mcand_q <= mag1;
        prod_q  <= {{XLEN{1'b0}}, mag2};
        cnt     <= '0;
      end else if (state == RUN) begin
        prod_q <= prod_nxt;
        cnt    <= cnt + 6'd1;
      end else if (state == NEG) begin
        prod_q <= prod_nxt;
      end
      if (state_nxt == DONE && state != DONE)
        rd_q <= (op_q == MUL) ? prod_nxt[XLEN-1:0] : prod_nxt[2*XLEN-1:XLEN];
    end
  end

  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_imul.sv
// Directed bench for imul: per-cycle compare against an arithmetic reference
// plus literal expectations on result value and writeback cycle.
module tb_imul;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imul_if #(.XLEN(32)) bus();
  imul #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference state
  bit          busy = 1'b0;
  int          due = 0;
  logic [31:0] res = '0;
  logic [31:0] last_rd = '0;

  // writeback monitor
  int          wb_cnt = 0;
  int          wb_cyc = 0;
  logic [31:0] wb_rd = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result and negate-cycle flag from plain signed/unsigned 64-bit arithmetic.
  task automatic ref_mul(input logic [3:0] mi, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
    bit sa, sb;
    longint xa, xb, p;
    sa = mi[0] | mi[1] | mi[2];
    sb = mi[0] | mi[1];
    xa = sa ? longint'(signed'(a)) : longint'(a);
    xb = sb ? longint'(signed'(b)) : longint'(b);
    p  = xa * xb;
    r  = mi[0] ? p[31:0] : p[63:32];
    lat = 33 + int'((sa & a[31]) ^ (sb & b[31]));
  endtask

  // Reference update at each clock edge from the inputs held during the cycle.
  always @(posedge clk) begin
    logic [31:0] r;
    int lat;
    if (!reset) begin
      busy = 1'b0;
      last_rd = '0;
    end else if (busy && cyc == due) begin
      last_rd = res;
      busy = 1'b0;
    end else if (busy && bus.kill) begin
      busy = 1'b0;
    end else if (!busy && !bus.kill && $onehot(bus.mul_inst)) begin
      ref_mul(bus.mul_inst, bus.rs1_data, bus.rs2_data, r, lat);
      res = r;
      due = cyc + lat;
      busy = 1'b1;
    end
    cyc++;
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_wb, exp_stall;
    if (cyc > 0) begin
      exp_wb    = busy && (cyc == due);
      exp_stall = busy ? (cyc < due) : (!bus.kill && $onehot(bus.mul_inst));
      chk("mul_wb", 32'(bus.mul_wb), 32'(exp_wb));
      chk("stall_i", 32'(bus.stall_i), 32'(exp_stall));
      chk("rd_data", bus.rd_data, exp_wb ? res : last_rd);
      if (bus.mul_wb === 1'b1) begin
        wb_cnt++;
        wb_cyc = cyc;
        wb_rd  = bus.rd_data;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(logic [3:0] mi, logic [31:0] a, logic [31:0] b);
    bus.mul_inst = mi;
    bus.rs1_data = a;
    bus.rs2_data = b;
    tick(1);
    bus.mul_inst = '0;
  endtask

  task automatic op_check(string nm, logic [3:0] mi, logic [31:0] a, logic [31:0] b,
                          int lat, logic [31:0] exp);
    int w0 = wb_cnt;
    int t = cyc;
    go(mi, a, b);
    tick(lat + 3);
    chk({nm, " count"}, wb_cnt - w0, 1);
    chk({nm, " latency"}, wb_cyc - t, lat);
    chk({nm, " rd"}, wb_rd, exp);
  endtask

  initial begin
    int w0, t;
    bus.mul_inst = '0;
    bus.kill = 1'b0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    reset = 1'b0;
    tick(3);
    chk("reset stall", 32'(bus.stall_i), 0);
    chk("reset wb", 32'(bus.mul_wb), 0);
    chk("reset rd", bus.rd_data, 0);
    reset = 1'b1;
    tick(1);

    op_check("mulhu ff", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
    op_check("mul -3x7", 4'b0001, 32'hFFFFFFFD, 32'd7, 34, 32'hFFFFFFEB);
    op_check("mulh min", 4'b0010, 32'h80000000, 32'h80000000, 33, 32'h40000000);
    op_check("mulhsu ff", 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFF);
    op_check("mul 0x-5", 4'b0001, 32'd0, 32'hFFFFFFFB, 34, 32'd0);
    op_check("mul 5x6", 4'b0001, 32'd5, 32'd6, 33, 32'd30);
    op_check("mulh -7x3", 4'b0010, 32'hFFFFFFF9, 32'd3, 34, 32'hFFFFFFFF);

    // back-to-back: second start in the cycle after DONE
    w0 = wb_cnt; t = cyc;
    go(4'b0001, 32'd5, 32'd6);
    tick(33);
    go(4'b0001, 32'd7, 32'd8);
    tick(36);
    chk("b2b count", wb_cnt - w0, 2);
    chk("b2b latency", wb_cyc - t, 34 + 33);
    chk("b2b rd", wb_rd, 32'd56);

    // kill during DONE still lets that pulse through
    w0 = wb_cnt; t = cyc;
    go(4'b0001, 32'd5, 32'd6);
    tick(32);
    bus.kill = 1'b1;
    tick(1);
    bus.kill = 1'b0;
    tick(20);
    chk("kill done count", wb_cnt - w0, 1);
    chk("kill done latency", wb_cyc - t, 33);
    chk("kill done rd", wb_rd, 32'd30);

    // kill at T+10, restart at T+11
    w0 = wb_cnt; t = cyc;
    go(4'b0001, 32'd5, 32'd6);
    tick(9);
    bus.kill = 1'b1;
    tick(1);
    bus.kill = 1'b0;
    #1;
    chk("kill stall", 32'(bus.stall_i), 0);
    go(4'b0001, 32'd2, 32'd3);
    tick(36);
    chk("kill count", wb_cnt - w0, 1);
    chk("kill latency", wb_cyc - t, 44);
    chk("kill rd", wb_rd, 32'd6);

    // start during RUN is ignored
    w0 = wb_cnt; t = cyc;
    go(4'b0001, 32'd9, 32'd9);
    tick(4);
    go(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick(35);
    chk("busy start count", wb_cnt - w0, 1);
    chk("busy start latency", wb_cyc - t, 33);
    chk("busy start rd", wb_rd, 32'd81);

    // kill and start in the same IDLE cycle
    w0 = wb_cnt;
    bus.kill = 1'b1;
    bus.mul_inst = 4'b0001;
    bus.rs1_data = 32'd2;
    bus.rs2_data = 32'd3;
    #1;
    chk("kill+start stall", 32'(bus.stall_i), 0);
    tick(1);
    bus.kill = 1'b0;
    bus.mul_inst = '0;
    tick(40);
    chk("kill+start count", wb_cnt - w0, 0);

    // two request bits set: ignored
    w0 = wb_cnt;
    bus.mul_inst = 4'b0011;
    #1;
    chk("multi-bit stall", 32'(bus.stall_i), 0);
    tick(1);
    bus.mul_inst = '0;
    tick(40);
    chk("multi-bit count", wb_cnt - w0, 0);

    // reset at T+20
    w0 = wb_cnt;
    go(4'b0001, 32'd5, 32'd6);
    tick(19);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    chk("mid reset stall", 32'(bus.stall_i), 0);
    chk("mid reset rd", bus.rd_data, 0);
    tick(40);
    chk("mid reset count", wb_cnt - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
